// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter: opcode and FSM state encodings.
package alu_pkg;

    localparam int unsigned NumReq = 2;
    localparam int unsigned OpW    = 3;

    typedef enum logic [OpW-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_EQ  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Command/response bus between two requesters, the shared ALU and its result consumer.
interface alu_arbiter_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic [1:0]             req_valid_i;
    logic [1:0]             req_ready_o;
    logic [1:0][DATA_W-1:0] req_a_i;
    logic [1:0][DATA_W-1:0] req_b_i;
    logic [1:0][2:0]        req_op_i;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i;
    logic                   rsp_id_o;
    logic [DATA_W-1:0]      rsp_data_o;
    logic                   busy_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_op_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, busy_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_op_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, busy_o
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU shared by both requesters.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  op_e               op_i,
    output logic [DATA_W-1:0] alu_o
);

    always_comb begin
        alu_o = '0;
        case (op_i)
            OP_ADD:  alu_o = a_i + b_i;
            OP_SUB:  alu_o = a_i - b_i;
            // Shift by three and fill the vacated bits from B[2:0]
            OP_SHL:  alu_o = {a_i[DATA_W-4:0], b_i[2:0]};
            OP_SHR:  alu_o = {b_i[2:0], a_i[DATA_W-1:3]};
            OP_AND:  alu_o = a_i & b_i;
            OP_OR:   alu_o = a_i | b_i;
            OP_XOR:  alu_o = a_i ^ b_i;
            OP_EQ:   alu_o = {{(DATA_W-1){1'b0}}, (a_i == b_i)};
            default: alu_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters (IDLE/EXEC/RESP).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input logic         clk,
    input logic         reset,
    alu_arbiter_if.slave bus
);

    if (DATA_W < 4) begin : g_width_check
        $error("alu_arbiter: DATA_W must be at least 4");
    end

    state_e            state_q, state_d;
    logic              ptr_q;
    logic              gnt_any;
    logic              gnt_idx;
    logic [DATA_W-1:0] a_q, b_q;
    op_e               op_q;
    logic              id_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] alu_res;
    logic              rsp_done;

    // Grant only from IDLE and never in the reset cycle; pointer breaks ties.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        if (state_q == StIdle && !reset) begin
            case (bus.req_valid_i)
                2'b01: begin
                    gnt_any = 1'b1;
                    gnt_idx = 1'b0;
                end
                2'b10: begin
                    gnt_any = 1'b1;
                    gnt_idx = 1'b1;
                end
                2'b11: begin
                    gnt_any = 1'b1;
                    gnt_idx = ptr_q;
                end
                default: ;
            endcase
        end
    end

    assign rsp_done = (state_q == StResp) && bus.rsp_ready_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (gnt_any) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (bus.rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            id_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (gnt_any) begin
                a_q  <= bus.req_a_i[gnt_idx];
                b_q  <= bus.req_b_i[gnt_idx];
                op_q <= op_e'(bus.req_op_i[gnt_idx]);
                id_q <= gnt_idx;
            end
            if (state_q == StExec) begin
                data_q <= alu_res;
            end
            if (rsp_done) begin
                ptr_q <= ~ptr_q;
            end
        end
    end

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .a_i   (a_q),
        .b_i   (b_q),
        .op_i  (op_q),
        .alu_o (alu_res)
    );

    assign bus.req_ready_o = gnt_any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid_o = (state_q == StResp);
    assign bus.rsp_id_o    = id_q;
    assign bus.rsp_data_o  = data_q;
    assign bus.busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scenario tasks drive the arbiter; a response monitor pops the expected-result scoreboard.
module tb_alu_arbiter;

    localparam int unsigned DW = 8;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(DW)) bus ();

    alu_arbiter #(
        .DATA_W (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Independent reference: arithmetic formulation of each opcode.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        int t;
        case (op)
            3'd0:    t = int'(a) + int'(b);
            3'd1:    t = int'(a) - int'(b) + 256;
            3'd2:    t = int'(a) * 8 + int'(b) % 8;
            3'd3:    t = int'(a) / 8 + (int'(b) % 8) * 32;
            3'd4:    t = int'(a & b);
            3'd5:    t = int'(a | b);
            3'd6:    t = int'(a ^ b);
            default: t = (a == b) ? 1 : 0;
        endcase
        return t[7:0];
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.rsp_valid_o && bus.rsp_ready_i) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got id=%0d data=%02h, want no response",
                         bus.rsp_id_o, bus.rsp_data_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.rsp_id_o !== e.id || bus.rsp_data_o !== e.data) begin
                    n_fail++;
                    $display("FAIL rsp_check: got id=%0d data=%02h, want id=%0d data=%02h",
                             bus.rsp_id_o, bus.rsp_data_o, e.id, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
    task automatic issue(input int n, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
        bit   got = 0;
        exp_t e;
        bus.req_a_i[n]     = a;
        bus.req_b_i[n]     = b;
        bus.req_op_i[n]    = op;
        bus.req_valid_i[n] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.req_ready_o[n]) begin
                got = 1;
                break;
            end
        end
        n_tests++;
        if (!got || bus.req_ready_o !== 2'(1 << n)) begin
            n_fail++;
            $display("FAIL issue_grant: got ready=%b, want %b", bus.req_ready_o, 2'(1 << n));
        end
        e.id   = n[0];
        e.data = model(a, b, op);
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid_i[n] = 1'b0;
        bus.req_a_i[n]     = 8'($urandom);
        bus.req_b_i[n]     = 8'($urandom);
        bus.req_op_i[n]    = 3'($urandom);
    endtask

    task automatic drain(input string name);
        bit done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy_o) begin
                done = 1;
                break;
            end
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: got pending=%0d busy=%b, want 0 and 0",
                     name, sb.size(), bus.busy_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.req_valid_i = 2'b11;
        bus.rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.req_ready_o !== 2'b00 || bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready=%b valid=%b busy=%b, want 00 0 0",
                     bus.req_ready_o, bus.rsp_valid_o, bus.busy_o);
        end
        n_tests++;
        if (bus.rsp_id_o !== 1'b0 || bus.rsp_data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rsp: got id=%b data=%02h, want 0 00",
                     bus.rsp_id_o, bus.rsp_data_o);
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 2'b00;
        reset           = 1'b0;
    endtask

    task automatic test_add_wrap();
        bus.rsp_ready_i = 1'b1;
        issue(0, 8'hFF, 8'h01, 3'b000);
        @(negedge clk);
        n_tests++;
        if (bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_t1: got valid=%b busy=%b, want 0 1", bus.rsp_valid_o, bus.busy_o);
        end
        @(negedge clk);
        n_tests++;
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 1'b0 || bus.rsp_data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_t2: got valid=%b id=%b data=%02h, want 1 0 00",
                     bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_data_o);
        end
        @(negedge clk);
        n_tests++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_idle: got busy=%b, want 0", bus.busy_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_shift();
        issue(0, 8'h01, 8'h05, 3'b010);
        drain("shl");
        issue(1, 8'h80, 8'h07, 3'b011);
        drain("shr");
    endtask

    task automatic test_ops();
        logic [7:0] ta[3] = '{8'h3C, 8'h3C, 8'h00};
        logic [7:0] tb[3] = '{8'h3C, 8'h3D, 8'h01};
        logic [2:0] to[3] = '{3'b111, 3'b111, 3'b001};
        for (int i = 0; i < 3; i++) begin
            issue(i % 2, ta[i], tb[i], to[i]);
            drain("eq_sub");
        end
        for (int op = 0; op < 8; op++) begin
            issue(op % 2, 8'($urandom), 8'($urandom), 3'(op));
            drain("op_sweep");
        end
    endtask

    task automatic test_backpressure();
        bus.rsp_ready_i = 1'b0;
        issue(1, 8'h12, 8'h34, 3'b101);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_a_i[0]     = 8'h11;
        bus.req_b_i[0]     = 8'h22;
        bus.req_op_i[0]    = 3'b000;
        bus.req_valid_i[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 1'b1 ||
                bus.rsp_data_o !== 8'h36 || bus.req_ready_o !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_hold: got valid=%b id=%b data=%02h ready=%b, want 1 1 36 00",
                         bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_data_o, bus.req_ready_o);
            end
        end
        @(posedge clk);
        #1;
        bus.rsp_ready_i    = 1'b1;
        bus.req_valid_i[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.busy_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_release: got busy=%b valid=%b ready=%b, want 0 0 00",
                     bus.busy_o, bus.rsp_valid_o, bus.req_ready_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        bus.rsp_ready_i = 1'b1;
        issue(0, 8'h55, 8'h0F, 3'b000);
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.rsp_data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_state: got valid=%b busy=%b data=%02h, want 0 0 00",
                     bus.rsp_valid_o, bus.busy_o, bus.rsp_data_o);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) seen = 1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL midreset_rsp: got late response, want none");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_contention();
        int   k = 0;
        int   last = -3;
        exp_t e;
        reset           = 1'b1;
        bus.rsp_ready_i = 1'b1;
        bus.req_a_i[0]  = 8'h01;
        bus.req_b_i[0]  = 8'h02;
        bus.req_op_i[0] = 3'b000;
        bus.req_a_i[1]  = 8'hF0;
        bus.req_b_i[1]  = 8'h0F;
        bus.req_op_i[1] = 3'b110;
        bus.req_valid_i = 2'b11;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            @(negedge clk);
            if (bus.req_ready_o !== 2'b00) begin
                n_tests++;
                if (bus.req_ready_o !== ((k % 2) ? 2'b10 : 2'b01) || c - last != 3) begin
                    n_fail++;
                    $display("FAIL contention_grant%0d: got ready=%b gap=%0d, want %b gap=3",
                             k, bus.req_ready_o, c - last, (k % 2) ? 2'b10 : 2'b01);
                end
                e.id   = k[0];
                e.data = (k % 2) ? 8'hFF : 8'h03;
                sb.push_back(e);
                last = c;
                k++;
            end
        end
        n_tests++;
        if (k != 4) begin
            n_fail++;
            $display("FAIL contention_count: got %0d grants, want 4", k);
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 2'b00;
        drain("contention");
    endtask

    initial begin
        bus.req_valid_i = 2'b00;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        bus.req_op_i    = '0;
        bus.rsp_ready_i = 1'b0;
        test_reset();
        test_add_wrap();
        test_shift();
        test_ops();
        test_backpressure();
        test_reset_mid();
        test_contention();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
